// File: rtl/fitness_timer_pkg.sv
// -----------------------------------------------------------------------------
// fitness_timer_pkg
// Shared definitions for the fitness timer audio path.
//   - pattern_e : beep pattern identifiers (none / interval / rest / done)
//   - state_e   : buzzer sequencer FSM states
//   - tone_count: number of tones that make up each pattern
// -----------------------------------------------------------------------------
package fitness_timer_pkg;

  // Pattern IDs double as priorities: a larger value outranks a smaller one.
  typedef enum logic [1:0] {
    PAT_NONE     = 2'd0,
    PAT_INTERVAL = 2'd1,
    PAT_REST     = 2'd2,
    PAT_DONE     = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Width of the tone index within a pattern (up to three tones).
  localparam int TONE_IDX_W = 2;

  // Number of tones played by each pattern.
  function automatic logic [TONE_IDX_W-1:0] tone_count(input pattern_e pattern);
    logic [TONE_IDX_W-1:0] count;
    case (pattern)
      PAT_INTERVAL: count = 2'd1;
      PAT_REST:     count = 2'd2;
      PAT_DONE:     count = 2'd3;
      default:      count = 2'd0;
    endcase
    return count;
  endfunction

endpackage

// File: rtl/buzzer_pattern_rom.sv
// -----------------------------------------------------------------------------
// buzzer_pattern_rom
// Combinational lookup of one tone within a beep pattern.
//
// Ports:
//   pattern   in   pattern ID (pattern_e)
//   tone_idx  in   tone index within the pattern (0-based)
//   freq      out  frequency_select value for this tone (0 if out of range)
//   length    out  tone length in ticks (raw table value, may be 0)
//   is_last   out  1 when tone_idx is the final tone of the pattern
// -----------------------------------------------------------------------------
module buzzer_pattern_rom
  import fitness_timer_pkg::*;
#(
  parameter int                DUR_W      = 8,
  parameter logic [15:0]       FREQ_HIGH  = 16'd4,
  parameter logic [15:0]       FREQ_MID   = 16'd6,
  parameter logic [15:0]       FREQ_LOW   = 16'd8,
  parameter logic [DUR_W-1:0]  TONE_SHORT = DUR_W'(100),
  parameter logic [DUR_W-1:0]  TONE_LONG  = DUR_W'(250)
) (
  input  pattern_e               pattern,
  input  logic [TONE_IDX_W-1:0]  tone_idx,
  output logic [15:0]            freq,
  output logic [DUR_W-1:0]       length,
  output logic                   is_last
);

  logic [TONE_IDX_W-1:0] n_tones;

  assign n_tones = tone_count(pattern);
  assign is_last = (n_tones != '0) && (tone_idx == n_tones - 2'd1);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    freq   = '0;
    length = '0;
    case (pattern)
      PAT_INTERVAL: begin
        if (tone_idx == 2'd0) begin
          freq   = FREQ_HIGH;
          length = TONE_SHORT;
        end
      end
      PAT_REST: begin
        if (tone_idx <= 2'd1) begin
          freq   = FREQ_MID;
          length = TONE_SHORT;
        end
      end
      PAT_DONE: begin
        // Falling chime: high, mid, then a long low tone.
        case (tone_idx)
          2'd0: begin
            freq   = FREQ_HIGH;
            length = TONE_SHORT;
          end
          2'd1: begin
            freq   = FREQ_MID;
            length = TONE_SHORT;
          end
          2'd2: begin
            freq   = FREQ_LOW;
            length = TONE_LONG;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/buzzer_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// buzzer_pattern_sequencer
// Turns one-cycle workout events into timed beep patterns that drive the
// frequency_generator. Durations are counted in timebase tick strobes.
//
// Ports:
//   clk               in   divided clock shared with frequency_generator
//   rst_n             in   synchronous active-low reset
//   tick              in   one-cycle timebase strobe
//   evt_interval      in   interval finished -> single high beep
//   evt_rest          in   rest started      -> double mid beep
//   evt_done          in   workout complete  -> high/mid/low chime
//   mute              in   level; gates buzz_enable only
//   buzz_enable       out  frequency_generator enable
//   frequency_select  out  frequency_generator period select
//   busy              out  pattern in progress
//   active_pattern    out  current pattern ID, 0 when idle
//   pattern_done      out  one-cycle pulse on natural pattern completion
// -----------------------------------------------------------------------------
module buzzer_pattern_sequencer
  import fitness_timer_pkg::*;
#(
  parameter int                DUR_W      = 8,
  parameter logic [15:0]       FREQ_HIGH  = 16'd4,
  parameter logic [15:0]       FREQ_MID   = 16'd6,
  parameter logic [15:0]       FREQ_LOW   = 16'd8,
  parameter logic [DUR_W-1:0]  TONE_SHORT = DUR_W'(100),
  parameter logic [DUR_W-1:0]  TONE_LONG  = DUR_W'(250),
  parameter logic [DUR_W-1:0]  GAP_LEN    = DUR_W'(80)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         evt_interval,
  input  logic         evt_rest,
  input  logic         evt_done,
  input  logic         mute,
  output logic         buzz_enable,
  output logic [15:0]  frequency_select,
  output logic         busy,
  output logic [1:0]   active_pattern,
  output logic         pattern_done
);

  // A zero length would never see the counter reach 1; treat it as 1 tick.
  localparam logic [DUR_W-1:0] GAP_LOAD = (GAP_LEN == '0) ? DUR_W'(1) : GAP_LEN;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q,   state_d;
  pattern_e               pat_q,     pat_d;
  logic [TONE_IDX_W-1:0]  idx_q,     idx_d;
  logic [DUR_W-1:0]       cnt_q,     cnt_d;
  logic                   done_d;

  // Next values of the registered outputs.
  logic                   buzz_enable_d;
  logic [15:0]            frequency_select_d;
  logic                   busy_d;
  logic [1:0]             active_pattern_d;

  // ---------------------------------------------------------------------------
  // Event priority and acceptance
  // ---------------------------------------------------------------------------
  pattern_e evt_pat;
  logic     accept;

  always_comb begin
    if (evt_done)          evt_pat = PAT_DONE;
    else if (evt_rest)     evt_pat = PAT_REST;
    else if (evt_interval) evt_pat = PAT_INTERVAL;
    else                   evt_pat = PAT_NONE;
  end

  // pat_q is PAT_NONE whenever idle, so one comparison covers both starting
  // from IDLE and preempting a lower-priority pattern. Equal or lower
  // priority events fall through and are dropped.
  assign accept = (evt_pat > pat_q);

  // ---------------------------------------------------------------------------
  // Pattern table lookup
  // ---------------------------------------------------------------------------
  // One ROM port serves every use: on acceptance it points at t0 of the new
  // pattern; during a gap it points at the tone about to start; during a tone
  // it points at the current tone (for is_last and the held frequency).
  pattern_e               rom_pat;
  logic [TONE_IDX_W-1:0]  rom_idx;
  logic [15:0]            rom_freq;
  logic [DUR_W-1:0]       rom_length;
  logic                   rom_last;
  logic [DUR_W-1:0]       tone_load;

  always_comb begin
    rom_pat = pat_q;
    rom_idx = idx_q;
    if (accept) begin
      rom_pat = evt_pat;
      rom_idx = '0;
    end else if (state_q == ST_GAP) begin
      rom_idx = idx_q + 2'd1;
    end
  end

  buzzer_pattern_rom #(
    .DUR_W      (DUR_W),
    .FREQ_HIGH  (FREQ_HIGH),
    .FREQ_MID   (FREQ_MID),
    .FREQ_LOW   (FREQ_LOW),
    .TONE_SHORT (TONE_SHORT),
    .TONE_LONG  (TONE_LONG)
  ) u_rom (
    .pattern  (rom_pat),
    .tone_idx (rom_idx),
    .freq     (rom_freq),
    .length   (rom_length),
    .is_last  (rom_last)
  );

  assign tone_load = (rom_length == '0) ? DUR_W'(1) : rom_length;

  // ---------------------------------------------------------------------------
  // State register (also holds the registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      pat_q            <= PAT_NONE;
      idx_q            <= '0;
      cnt_q            <= '0;
      buzz_enable      <= 1'b0;
      frequency_select <= '0;
      busy             <= 1'b0;
      active_pattern   <= '0;
      pattern_done     <= 1'b0;
    end else begin
      state_q          <= state_d;
      pat_q            <= pat_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      buzz_enable      <= buzz_enable_d;
      frequency_select <= frequency_select_d;
      busy             <= busy_d;
      active_pattern   <= active_pattern_d;
      pattern_done     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (accept) begin
      // A tick on the accepting edge is deliberately not counted.
      state_d = ST_TONE;
      pat_d   = evt_pat;
      idx_d   = '0;
      cnt_d   = tone_load;
    end else if (state_q != ST_IDLE && tick) begin
      if (cnt_q <= DUR_W'(1)) begin
        case (state_q)
          ST_TONE: begin
            if (rom_last) begin
              state_d = ST_IDLE;
              pat_d   = PAT_NONE;
              idx_d   = '0;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_LOAD;
            end
          end
          ST_GAP: begin
            state_d = ST_TONE;
            idx_d   = idx_q + 2'd1;
            cnt_d   = tone_load;
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q - DUR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (computed from the next state, registered above)
  // ---------------------------------------------------------------------------
  // Whenever state_d is TONE the ROM is addressed at that tone, so rom_freq
  // is the frequency to present after the edge.
  always_comb begin
    buzz_enable_d      = 1'b0;
    frequency_select_d = '0;
    busy_d             = (state_d != ST_IDLE);
    active_pattern_d   = pat_d;
    if (state_d == ST_TONE) begin
      buzz_enable_d      = !mute;
      frequency_select_d = rom_freq;
    end
  end

endmodule

// File: tb/tb_buzzer_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_buzzer_pattern_sequencer
// Directed scenarios with literal expectations, then randomized events, mute,
// reset and ticks. A schedule-queue model tracks the expected outputs and is
// compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_buzzer_pattern_sequencer;

  localparam int TS  = 2;  // short tone, ticks
  localparam int TL  = 4;  // long tone, ticks
  localparam int GAP = 1;  // gap, ticks

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        evt_interval;
  logic        evt_rest;
  logic        evt_done;
  logic        mute;
  logic        buzz_enable;
  logic [15:0] frequency_select;
  logic        busy;
  logic [1:0]  active_pattern;
  logic        pattern_done;

  always #5 clk = ~clk;

  buzzer_pattern_sequencer #(
    .DUR_W      (8),
    .FREQ_HIGH  (16'd4),
    .FREQ_MID   (16'd6),
    .FREQ_LOW   (16'd8),
    .TONE_SHORT (8'd2),
    .TONE_LONG  (8'd4),
    .GAP_LEN    (8'd1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tick             (tick),
    .evt_interval     (evt_interval),
    .evt_rest         (evt_rest),
    .evt_done         (evt_done),
    .mute             (mute),
    .buzz_enable      (buzz_enable),
    .frequency_select (frequency_select),
    .busy             (busy),
    .active_pattern   (active_pattern),
    .pattern_done     (pattern_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: on acceptance the whole pattern is expanded into a queue
  // of segments (freq, ticks); freq 0 marks a silent gap. Ticks consume the
  // head segment; an emptied queue means the pattern finished.
  // ---------------------------------------------------------------------------
  function automatic int n_tones(input int p);
    return p;  // interval 1 tone, rest 2, done 3
  endfunction

  function automatic int t_freq(input int p, input int i);
    if (p == 1) return 4;
    if (p == 2) return 6;
    return (i == 0) ? 4 : (i == 1) ? 6 : 8;
  endfunction

  function automatic int t_len(input int p, input int i);
    int len;
    len = (p == 3 && i == 2) ? TL : TS;
    return (len == 0) ? 1 : len;
  endfunction

  int   sq_freq[$];
  int   sq_len[$];
  int   m_pat  = 0;
  int   m_ep;
  bit   m_done = 0;
  bit   m_busy = 0;
  bit   m_en   = 0;
  int   m_freq = 0;

  always @(posedge clk) begin
    m_done = 0;
    if (!rst_n) begin
      sq_freq.delete();
      sq_len.delete();
      m_pat = 0;
    end else begin
      m_ep = evt_done ? 3 : evt_rest ? 2 : evt_interval ? 1 : 0;
      if (m_ep > m_pat) begin
        sq_freq.delete();
        sq_len.delete();
        for (int i = 0; i < n_tones(m_ep); i++) begin
          sq_freq.push_back(t_freq(m_ep, i));
          sq_len.push_back(t_len(m_ep, i));
          if (i < n_tones(m_ep) - 1) begin
            sq_freq.push_back(0);
            sq_len.push_back((GAP == 0) ? 1 : GAP);
          end
        end
        m_pat = m_ep;
      end else if (sq_len.size() > 0 && tick) begin
        sq_len[0] = sq_len[0] - 1;
        if (sq_len[0] == 0) begin
          void'(sq_len.pop_front());
          void'(sq_freq.pop_front());
          if (sq_len.size() == 0) begin
            m_done = 1;
            m_pat  = 0;
          end
        end
      end
    end
    m_busy = (sq_len.size() > 0);
    m_freq = m_busy ? sq_freq[0] : 0;
    m_en   = m_busy && (m_freq != 0) && !mute;
  end

  bit cmp_on = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      check("buzz_enable",      32'(buzz_enable),      32'(m_en));
      check("frequency_select", 32'(frequency_select), 32'(m_freq));
      check("busy",             32'(busy),             32'(m_busy));
      check("active_pattern",   32'(active_pattern),   32'(m_pat));
      check("pattern_done",     32'(pattern_done),     32'(m_done));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int tick_cnt  = 0;
  bit rand_tick = 0;

  // Advance past the next rising edge, clear pulses, set tick for the edge after.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    evt_interval = 1'b0;
    evt_rest     = 1'b0;
    evt_done     = 1'b0;
    rst_n        = 1'b1;
    if (rand_tick) begin
      tick = ($urandom_range(0, 3) == 0);
    end else begin
      tick_cnt = (tick_cnt + 1) % 4;
      tick     = (tick_cnt == 0);
    end
  endtask

  // Align so that the event lands one edge after a tick (ticks then fall at
  // 3 and 7 edges after acceptance), making run lengths fixed.
  task automatic arm_event(input bit i, input bit r, input bit d);
    while (!tick) next_cycle();
    next_cycle();
    evt_interval = i;
    evt_rest     = r;
    evt_done     = d;
  endtask

  int run_f[16];
  int run_l[16];
  int run_n;
  int pd_seen;
  int en_seen;
  int bad_act;

  // Record DUT frequency runs until the pattern ends.
  task automatic trace(input int exp_act);
    bit ended;
    ended   = 0;
    run_n   = 0;
    pd_seen = 0;
    en_seen = 0;
    bad_act = 0;
    for (int c = 0; c < 200 && !ended; c++) begin
      next_cycle();
      @(negedge clk);
      if (pattern_done) pd_seen++;
      if (buzz_enable) en_seen++;
      if (!busy) begin
        ended = 1;
      end else begin
        if (32'(active_pattern) != exp_act) bad_act++;
        if (run_n > 0 && run_f[run_n-1] == 32'(frequency_select)) begin
          run_l[run_n-1]++;
        end else if (run_n < 16) begin
          run_f[run_n] = 32'(frequency_select);
          run_l[run_n] = 1;
          run_n++;
        end
      end
    end
    check("trace_ended", 32'(ended), 1);
  endtask

  task automatic check_p2_runs(input string tag);
    check({tag, "_runs"},  run_n,    3);
    check({tag, "_f0"},    run_f[0], 6);
    check({tag, "_l0"},    run_l[0], 7);
    check({tag, "_f1"},    run_f[1], 0);
    check({tag, "_l1"},    run_l[1], 4);
    check({tag, "_f2"},    run_f[2], 6);
    check({tag, "_l2"},    run_l[2], 8);
    check({tag, "_done"},  pd_seen,  1);
    check({tag, "_act"},   bad_act,  0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit found;
    rst_n        = 1'b0;
    tick         = 1'b0;
    evt_interval = 1'b0;
    evt_rest     = 1'b0;
    evt_done     = 1'b0;
    mute         = 1'b0;

    @(posedge clk);
    #1;
    cmp_on = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_en",   32'(buzz_enable),      0);
    check("rst_freq", 32'(frequency_select), 0);
    check("rst_busy", 32'(busy),             0);
    check("rst_act",  32'(active_pattern),   0);
    check("rst_done", 32'(pattern_done),     0);
    next_cycle();

    // Reset in the middle of the second chime tone.
    arm_event(0, 0, 1);
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      next_cycle();
      @(negedge clk);
      if (frequency_select == 16'd6) found = 1;
    end
    check("mid_reset_reach_t1", 32'(found), 1);
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    check("mid_reset_en",   32'(buzz_enable),      0);
    check("mid_reset_freq", 32'(frequency_select), 0);
    check("mid_reset_busy", 32'(busy),             0);
    check("mid_reset_act",  32'(active_pattern),   0);
    check("mid_reset_done", 32'(pattern_done),     0);
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      @(negedge clk);
      check("post_reset_quiet", 32'(pattern_done | busy), 0);
    end

    // Single high beep.
    arm_event(1, 0, 0);
    trace(1);
    check("p1_runs", run_n,    1);
    check("p1_f0",   run_f[0], 4);
    check("p1_l0",   run_l[0], 7);
    check("p1_en",   en_seen,  7);
    check("p1_done", pd_seen,  1);
    check("p1_end_freq", 32'(frequency_select), 0);
    check("p1_end_en",   32'(buzz_enable),      0);
    next_cycle();
    @(negedge clk);
    check("p1_done_one_cycle", 32'(pattern_done), 0);

    // Double mid beep.
    arm_event(0, 1, 0);
    trace(2);
    check_p2_runs("p2");
    check("p2_en", en_seen, 15);

    // Done and interval together: done wins.
    arm_event(1, 0, 1);
    trace(3);
    check("p3_runs", run_n,    5);
    check("p3_f0",   run_f[0], 4);
    check("p3_l0",   run_l[0], 7);
    check("p3_f1",   run_f[1], 0);
    check("p3_l1",   run_l[1], 4);
    check("p3_f2",   run_f[2], 6);
    check("p3_l2",   run_l[2], 8);
    check("p3_f3",   run_f[3], 0);
    check("p3_l3",   run_l[3], 4);
    check("p3_f4",   run_f[4], 8);
    check("p3_l4",   run_l[4], 16);
    check("p3_done", pd_seen,  1);
    check("p3_act",  bad_act,  0);

    // Rest preempts interval; a later interval is dropped.
    arm_event(1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
    end
    evt_rest = 1'b1;
    next_cycle();
    @(negedge clk);
    check("preempt_act",  32'(active_pattern),   2);
    check("preempt_freq", 32'(frequency_select), 6);
    check("preempt_done", 32'(pattern_done),     0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      check("preempt_no_done", 32'(pattern_done), 0);
    end
    evt_interval = 1'b1;
    next_cycle();
    @(negedge clk);
    check("drop_act", 32'(active_pattern), 2);
    trace(2);
    check("drop_done", pd_seen, 1);
    check("drop_act_hold", bad_act, 0);

    // Muted rest pattern: same timing, no enable.
    mute = 1'b1;
    arm_event(0, 1, 0);
    trace(2);
    check_p2_runs("mute");
    check("mute_en", en_seen, 0);
    mute = 1'b0;

    // Randomized phase.
    rand_tick = 1;
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      evt_interval = ($urandom_range(0, 29) == 0);
      evt_rest     = ($urandom_range(0, 39) == 0);
      evt_done     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
    end
    next_cycle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/buzzer_pattern_sequencer.md
Name: buzzer_pattern_sequencer

Overview:
Upstream stage of frequency_generator: converts one-cycle workout events into timed beep patterns.
Drives the generator's enable and frequency_select inputs.
- Interval end: single high beep.
- Rest start: double mid beep.
- Workout done: three-tone falling chime.
Runs on the same divided clock as frequency_generator; durations are counted in tick strobes from the timebase.

Parameters:
DUR_W, 8, width of duration counters
FREQ_HIGH, 16'd4, frequency_select for the high tone (clk cycles per period)
FREQ_MID, 16'd6, frequency_select for the mid tone
FREQ_LOW, 16'd8, frequency_select for the low tone
TONE_SHORT, 8'd100, short tone length in ticks
TONE_LONG, 8'd250, long tone length in ticks
GAP_LEN, 8'd80, silent gap between tones in ticks

Ports:
clk  in  1  system clock (divided clock shared with frequency_generator)
rst_n  in  1  synchronous active-low reset
tick  in  1  one-cycle timebase strobe; all durations count these
evt_interval  in  1  one-cycle pulse: interval finished
evt_rest  in  1  one-cycle pulse: rest period started
evt_done  in  1  one-cycle pulse: workout complete
mute  in  1  level; silences output without stopping sequencing
buzz_enable  out  1  to frequency_generator enable
frequency_select  out  16  to frequency_generator frequency_select
busy  out  1  pattern in progress (TONE or GAP)
active_pattern  out  2  0 none, 1 interval, 2 rest, 3 done
pattern_done  out  1  one-cycle pulse when a pattern completes naturally

Behaviour:
- One clock: clk. Reset is synchronous and active-low on rst_n, sampled at posedge clk. It applies in any state, including mid-pattern.
- Reset values: buzz_enable 0, frequency_select 0, busy 0, active_pattern 0, pattern_done 0. State is IDLE and all counters are 0.
- All outputs are registered.
- FSM has three states.
  - IDLE: waiting for an event.
  - TONE: buzz_enable = !mute; frequency_select = the current tone's value.
  - GAP: buzz_enable 0; frequency_select 0.
- Pattern table (tone index -> freq, length):
  - P1 interval: t0 FREQ_HIGH/TONE_SHORT.
  - P2 rest: t0 FREQ_MID/TONE_SHORT; t1 FREQ_MID/TONE_SHORT.
  - P3 done: t0 FREQ_HIGH/TONE_SHORT; t1 FREQ_MID/TONE_SHORT; t2 FREQ_LOW/TONE_LONG.
- Event acceptance latency: 1 cycle. Event sampled at edge k gives TONE t0 outputs valid after edge k.
- Priority: evt_done > evt_rest > evt_interval when asserted in the same cycle.
- Acceptance while busy:
  - Strictly higher priority event preempts. Restart at t0 of the new pattern, reload the counter, no pattern_done pulse.
  - Equal or lower priority event is dropped (no queue).
- Duration counting:
  - Entering TONE or GAP loads the counter with its length; a length of 0 is treated as 1.
  - The counter decrements only on tick.
  - The state ends at the edge where tick=1 and the counter is 1.
- Transitions:
  - TONE end, more tones left: go to GAP.
  - TONE end, last tone: go to IDLE and pulse pattern_done for exactly 1 cycle.
  - GAP end: go to TONE for the next tone index.
  - There is no gap after the last tone.
- An event in the cycle the last tone ends: state is still busy, so the priority rule applies. Higher priority preempts and there is no pattern_done. Otherwise the event is dropped and the pattern completes.
- tick asserted on the same edge an event is accepted is not counted toward the new tone.
- mute only gates buzz_enable; counters, busy, active_pattern and frequency_select are unaffected.
- busy = (state != IDLE). active_pattern is the current pattern ID, or 0 in IDLE.

Decomposition:
- Shared package fitness_timer_pkg holds:
  - pattern ID constants (PAT_NONE, PAT_INTERVAL, PAT_REST, PAT_DONE);
  - FSM state encoding (ST_IDLE, ST_TONE, ST_GAP);
  - tone count per pattern.
- Sub-module buzzer_pattern_rom: combinational (pattern ID, tone index) -> (freq, length, is_last). The sequencer owns the FSM and counters.

Test Plan:
Bench uses TONE_SHORT=2, TONE_LONG=4, GAP_LEN=1, with tick every 4 clk cycles.
1. Reset mid-tone: start P3, assert rst_n=0 for 1 edge during t1 -> next cycle all outputs 0, state IDLE; no pattern_done.
2. evt_interval alone -> buzz_enable=1 and frequency_select=4 one cycle later, held for 2 ticks; then buzz_enable 0, frequency_select 0, pattern_done pulses once, busy 0.
3. evt_rest -> freq 6 for 2 ticks, silent for 1 tick, freq 6 for 2 ticks, then pattern_done; active_pattern=2 throughout.
4. evt_done and evt_interval in the same cycle -> P3 runs with freq sequence 4, 6, 8 and tone lengths 2/2/4 ticks; active_pattern=3.
5. During P1, pulse evt_rest -> P2 restarts at t0 the next cycle with no pattern_done for P1. During P2, pulse evt_interval -> ignored; P2 completes normally.
6. mute=1 through P2 -> buzz_enable stays 0, but frequency_select, busy and pattern_done timing are identical to scenario 3.
